// File: rtl/bus_pkg.sv
// Shared definitions for the 8086 minimum-mode bus-cycle master:
// T-state encoding plus the M/IO and read/write bit meanings.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_TW   = 3'd4,
    ST_T4   = 3'd5
  } bus_state_e;

  localparam logic MIO_MEM   = 1'b1;
  localparam logic MIO_IO    = 1'b0;
  localparam logic DIR_WRITE = 1'b1;
  localparam logic DIR_READ  = 1'b0;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter for TW: load to 1 on the first wait, count up per wait,
// and flag when the wait budget is used up.
module bus_wait_timer #(
  parameter int WAIT_MAX = 16,
  parameter int WAIT_W   = 5
) (
  input  logic clk,
  input  logic RESET,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic expired
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = WAIT_W'(1);
    end else if (inc) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == WAIT_W'(WAIT_MAX));

endmodule

// File: rtl/bus_cycle_master.sv
// Request/acknowledge front end that runs 8086-style multiplexed bus cycles
// (T1-T2-T3-TW*-T4), advancing only on the CPU-rate t_en strobe.
module bus_cycle_master
  import bus_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int WAIT_W   = 5
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        t_en,
  input  logic        req,
  input  logic        req_we,
  input  logic        req_mio,
  input  logic [19:0] req_addr,
  input  logic        req_bhe_n,
  input  logic [15:0] req_wdata,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        ALE,
  output logic        M_IO,
  output logic        RD,
  output logic        WR,
  output logic        DEN,
  output logic        DT_R,
  output logic        BHE_S7,
  output logic [19:0] LAD_out,
  output logic        LAD_oe,
  input  logic [15:0] LAD_in,
  input  logic        READY
);

  bus_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic        mio_q, mio_d;
  logic [19:0] addr_q, addr_d;
  logic        bhe_q, bhe_d;
  logic [15:0] wdata_q, wdata_d;
  logic        abort_q, abort_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic        start;
  logic        wait_clr, wait_load, wait_inc, wait_expired;

  bus_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .RESET   (RESET),
    .clr     (wait_clr),
    .load    (wait_load),
    .inc     (wait_inc),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      we_q    <= DIR_READ;
      mio_q   <= MIO_IO;
      addr_q  <= '0;
      bhe_q   <= 1'b1;
      wdata_q <= '0;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      mio_q   <= mio_d;
      addr_q  <= addr_d;
      bhe_q   <= bhe_d;
      wdata_q <= wdata_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Requests are accepted from IDLE or straight out of T4, giving back-to-back cycles.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    mio_d     = mio_q;
    addr_d    = addr_q;
    bhe_d     = bhe_q;
    wdata_d   = wdata_q;
    abort_d   = abort_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    start     = 1'b0;
    wait_clr  = 1'b0;
    wait_load = 1'b0;
    wait_inc  = 1'b0;
    if (t_en) begin
      case (state_q)
        ST_IDLE: begin
          start = req;
        end
        ST_T1: state_d = ST_T2;
        ST_T2: state_d = ST_T3;
        ST_T3: begin
          if (READY) begin
            state_d = ST_T4;
            rdata_d = LAD_in;
          end else begin
            state_d   = ST_TW;
            wait_load = 1'b1;
          end
        end
        ST_TW: begin
          if (READY) begin
            state_d = ST_T4;
            rdata_d = LAD_in;
          end else if (wait_expired) begin
            state_d = ST_T4;
            abort_d = 1'b1;
          end else begin
            wait_inc = 1'b1;
          end
        end
        ST_T4: begin
          ack_d    = ~abort_q;
          err_d    = abort_q;
          wait_clr = 1'b1;
          state_d  = ST_IDLE;
          start    = req;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (start) begin
      state_d = ST_T1;
      we_d    = req_we;
      mio_d   = req_mio;
      addr_d  = req_addr;
      bhe_d   = req_bhe_n;
      wdata_d = req_wdata;
      abort_d = 1'b0;
    end
  end

  // Bus pins decode purely from the registered state, so they only move on t_en edges.
  always_comb begin
    ALE     = 1'b0;
    RD      = 1'b1;
    WR      = 1'b1;
    DEN     = 1'b1;
    LAD_oe  = 1'b0;
    LAD_out = '0;
    busy    = 1'b1;
    BHE_S7  = bhe_q;
    DT_R    = we_q;
    M_IO    = mio_q;
    case (state_q)
      ST_IDLE: begin
        busy   = 1'b0;
        BHE_S7 = 1'b1;
      end
      ST_T1: begin
        ALE     = 1'b1;
        LAD_oe  = 1'b1;
        LAD_out = addr_q;
      end
      ST_T2, ST_T3, ST_TW: begin
        DEN = 1'b0;
        if (we_q == DIR_WRITE) begin
          WR      = 1'b0;
          LAD_oe  = 1'b1;
          LAD_out = {4'h0, wdata_q};
        end else begin
          RD = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_bus_cycle_master.sv
// Self-checking bench for bus_cycle_master: directed scenarios with literal
// expectations, then random traffic against a per-transaction period model.
module tb_bus_cycle_master;

  localparam int WAIT_MAX = 16;

  logic        clk = 1'b0;
  logic        RESET, t_en, req, req_we, req_mio, req_bhe_n, READY;
  logic [19:0] req_addr;
  logic [15:0] req_wdata, LAD_in;
  logic        ack, err, busy, ALE, M_IO, RD, WR, DEN, DT_R, BHE_S7, LAD_oe;
  logic [15:0] rdata;
  logic [19:0] LAD_out;
  logic [46:0] dut_vec;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // model: one transaction described by its length in t_en periods and period index
  bit          m_busy, m_to, m_we, m_bhe, m_dtr, m_mio_last, m_ack, m_err;
  int          m_p, m_len, m_nw;
  logic [19:0] m_addr;
  logic [15:0] m_wdata, m_rdata;

  bit          pd_valid, pd_we, pd_mio, pd_bhe, pd_to;
  logic [19:0] pd_addr;
  logic [15:0] pd_wdata;
  int          pd_nw;

  bit          lad_fix, seen_ack, seen_err, last_accept;
  logic [15:0] lad_val;

  bus_cycle_master #(.WAIT_MAX(WAIT_MAX), .WAIT_W(5)) dut (
    .clk(clk), .RESET(RESET), .t_en(t_en), .req(req), .req_we(req_we),
    .req_mio(req_mio), .req_addr(req_addr), .req_bhe_n(req_bhe_n),
    .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .ALE(ALE), .M_IO(M_IO), .RD(RD), .WR(WR), .DEN(DEN), .DT_R(DT_R),
    .BHE_S7(BHE_S7), .LAD_out(LAD_out), .LAD_oe(LAD_oe), .LAD_in(LAD_in),
    .READY(READY)
  );

  always #5 clk = ~clk;

  assign dut_vec = {ALE, M_IO, RD, WR, DEN, DT_R, BHE_S7, LAD_oe, busy, ack, err, LAD_out, rdata};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: no response within bound at %0t", name, $time);
  endtask

  function automatic logic [46:0] model_out();
    logic ale, rd, wr, den, oe, bsy, bhe;
    logic [19:0] lad;
    ale = 1'b0; rd = 1'b1; wr = 1'b1; den = 1'b1; oe = 1'b0; bsy = 1'b0; bhe = 1'b1;
    lad = '0;
    if (m_busy) begin
      bsy = 1'b1;
      bhe = m_bhe;
      if (m_p == 0) begin
        ale = 1'b1; oe = 1'b1; lad = m_addr;
      end else if (m_p < m_len - 1) begin
        den = 1'b0;
        if (m_we) begin
          wr = 1'b0; oe = 1'b1; lad = {4'h0, m_wdata};
        end else begin
          rd = 1'b0;
        end
      end
    end
    return {ale, m_mio_last, rd, wr, den, m_dtr, bhe, oe, bsy, m_ack, m_err, lad, m_rdata};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("outputs", 64'(dut_vec), 64'(model_out()));
      check("invariants", {61'b0, (!RD && !WR), (!DEN && ALE), (LAD_oe && !RD)}, 64'b0);
    end
  end

  // Advance the model across one t_en edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit can_take;
    can_take = !m_busy || (m_p == m_len - 1);
    last_accept = 1'b0;
    if (m_busy) begin
      if (m_p == m_len - 1) begin
        if (m_to) m_err = 1'b1;
        else      m_ack = 1'b1;
        m_busy = 1'b0;
      end else begin
        if (m_p == m_len - 2 && !m_to) m_rdata = LAD_in;
        m_p++;
      end
    end
    if (can_take && req) begin
      m_busy = 1'b1; m_p = 0;
      m_we = req_we; m_addr = req_addr; m_bhe = req_bhe_n; m_wdata = req_wdata;
      m_nw = pd_nw; m_to = pd_to;
      m_len = 4 + (pd_to ? WAIT_MAX : pd_nw);
      m_dtr = req_we; m_mio_last = req_mio;
      pd_valid = 1'b0;
      last_accept = 1'b1;
    end
  endtask

  task automatic drive_inputs();
    req = pd_valid;
    if (pd_valid) begin
      req_we = pd_we; req_mio = pd_mio; req_addr = pd_addr;
      req_bhe_n = pd_bhe; req_wdata = pd_wdata;
    end else begin
      req_we = 1'($urandom); req_mio = 1'($urandom); req_addr = 20'($urandom);
      req_bhe_n = 1'($urandom); req_wdata = 16'($urandom);
    end
    LAD_in = lad_fix ? lad_val : 16'($urandom);
    if (m_busy && m_p >= 2 && m_p <= m_len - 2)
      READY = m_to ? 1'b0 : ((m_p - 2) == m_nw);
    else
      READY = 1'($urandom);
  endtask

  task automatic step(input int gap);
    t_en = 1'b1;
    @(posedge clk);
    #1;
    m_ack = 1'b0; m_err = 1'b0;
    seen_ack = ack; seen_err = err;
    model_edge();
    drive_inputs();
    t_en = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
      m_ack = 1'b0; m_err = 1'b0;
    end
  endtask

  task automatic set_pend(input bit we, input bit mio, input logic [19:0] addr, input bit bhe,
                          input logic [15:0] wd, input int nw, input bit to);
    pd_valid = 1'b1; pd_we = we; pd_mio = mio; pd_addr = addr; pd_bhe = bhe;
    pd_wdata = wd; pd_nw = nw; pd_to = to;
    drive_inputs();
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step(int'($urandom_range(0, 2)));
      if (last_accept) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("accept");
  endtask

  task automatic wait_done(input int start, output int steps, output bit got_ack, output bit got_err);
    bit ok;
    ok = 1'b0; steps = start; got_ack = 1'b0; got_err = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step(int'($urandom_range(0, 2)));
      steps++;
      if (seen_ack || seen_err) begin
        got_ack = seen_ack; got_err = seen_err; ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("completion");
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_p = 0; m_len = 4; m_nw = 0; m_to = 1'b0;
    m_dtr = 1'b0; m_mio_last = 1'b0; m_rdata = '0; m_ack = 1'b0; m_err = 1'b0;
    m_we = 1'b0; m_bhe = 1'b1; m_addr = '0; m_wdata = '0;
    pd_valid = 1'b0; pd_nw = 0; pd_to = 1'b0;
  endtask

  initial begin
    int st;
    bit a, e;
    RESET = 1'b1; t_en = 1'b0; lad_fix = 1'b0; lad_val = '0;
    model_reset();
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ALE", 64'(ALE), 64'd0);
    check("rst_RD", 64'(RD), 64'd1);
    check("rst_WR", 64'(WR), 64'd1);
    check("rst_DEN", 64'(DEN), 64'd1);
    check("rst_DT_R", 64'(DT_R), 64'd0);
    check("rst_M_IO", 64'(M_IO), 64'd0);
    check("rst_BHE_S7", 64'(BHE_S7), 64'd1);
    check("rst_LAD", 64'({LAD_oe, LAD_out}), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_flags", 64'({ack, err, busy}), 64'd0);
    @(negedge clk);
    RESET = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] memory read");
    lad_fix = 1'b1; lad_val = 16'hBEEF;
    set_pend(1'b0, 1'b1, 20'h12345, 1'b0, 16'h0000, 0, 1'b0);
    wait_accept();
    check("t1_T1_pins", 64'({ALE, M_IO, DT_R, LAD_out}), 64'({1'b1, 1'b1, 1'b0, 20'h12345}));
    wait_done(0, st, a, e);
    check("t1_latency", 64'(st), 64'd4);
    check("t1_ack", 64'({a, e}), 64'b10);
    check("t1_rdata", 64'(rdata), 64'hBEEF);

    $display("[TB] io write");
    set_pend(1'b1, 1'b0, 20'h00030, 1'b1, 16'h0002, 0, 1'b0);
    wait_accept();
    check("t2_T1_pins", 64'({M_IO, DT_R, BHE_S7, LAD_out}), 64'({1'b0, 1'b1, 1'b1, 20'h00030}));
    step(1);
    check("t2_T2_pins", 64'({WR, RD, LAD_oe, LAD_out}), 64'({1'b0, 1'b1, 1'b1, 20'h00002}));
    wait_done(1, st, a, e);
    check("t2_latency", 64'(st), 64'd4);

    $display("[TB] read with three waits");
    lad_val = 16'h1357;
    set_pend(1'b0, 1'b1, 20'hA0F00, 1'b0, 16'h0000, 3, 1'b0);
    wait_accept();
    wait_done(0, st, a, e);
    check("t3_latency", 64'(st), 64'd7);
    check("t3_rdata", 64'(rdata), 64'h1357);

    $display("[TB] wait timeout");
    lad_val = 16'hDEAD;
    set_pend(1'b0, 1'b1, 20'h0F0F0, 1'b1, 16'h0000, 0, 1'b1);
    wait_accept();
    wait_done(0, st, a, e);
    check("t4_latency", 64'(st), 64'd20);
    check("t4_err_only", 64'({a, e}), 64'b01);
    check("t4_rdata_kept", 64'(rdata), 64'h1357);

    $display("[TB] back-to-back");
    lad_fix = 1'b0;
    set_pend(1'b0, 1'b1, 20'h11111, 1'b0, 16'h0000, 0, 1'b0);
    wait_accept();
    set_pend(1'b1, 1'b1, 20'h22222, 1'b1, 16'hCAFE, 1, 1'b0);
    wait_done(0, st, a, e);
    check("t5_first_latency", 64'(st), 64'd4);
    check("t5_second_T1", 64'({last_accept, ALE, DT_R, LAD_out}), 64'({1'b1, 1'b1, 1'b1, 20'h22222}));
    wait_done(0, st, a, e);
    check("t5_second_latency", 64'(st), 64'd5);

    $display("[TB] reset during write T3");
    set_pend(1'b1, 1'b1, 20'h33333, 1'b0, 16'h5555, 2, 1'b0);
    wait_accept();
    step(1);
    step(1);
    chk_en = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    check("t6_async_pins", 64'({WR, DEN, LAD_oe, busy, ALE, RD}), 64'b110001);
    model_reset();
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    RESET = 1'b0;
    check("t6_no_ack", 64'({ack, err, rdata}), 64'd0);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    lad_fix = 1'b1; lad_val = 16'h4242;
    set_pend(1'b0, 1'b0, 20'h00044, 1'b0, 16'h0000, 0, 1'b0);
    wait_accept();
    wait_done(0, st, a, e);
    check("t6_after_reset", 64'({st, 1'(a), rdata}), 64'({32'd4, 1'b1, 16'h4242}));

    $display("[TB] random traffic");
    lad_fix = 1'b0;
    for (int i = 0; i < 150; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      set_pend(1'($urandom), 1'($urandom), 20'($urandom), 1'($urandom), 16'($urandom),
               (r == 1) ? 16 : int'($urandom_range(0, 3)), (r == 0));
      wait_accept();
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < 30 && m_busy; k++) step(int'($urandom_range(0, 2)));
        repeat ($urandom_range(0, 3)) step(int'($urandom_range(0, 2)));
      end
    end
    for (int k = 0; k < 30 && m_busy; k++) step(int'($urandom_range(0, 2)));
    repeat (3) step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
